// File: rtl/acc_cpu_core.sv
// acc_cpu_core - parametrised accumulator CPU core.
//
// Executes one instruction per start request (step, or run when built with
// ACC_CPU_FREE_RUN_EN) and talks to an external RAM controller through a
// start/busy handshake: one-cycle start pulse, one dead cycle, then wait for
// mem_busy low and capture mem_rdata in that cycle.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   step                 start one instruction from IDLE
//   run                  (ACC_CPU_FREE_RUN_EN only) continuous execution
//   busy, halt, trap     status
//   data_in              IN instruction source (8 bit)
//   data_out             packed 8-bit output ports, port k = [8k+7:8k]
//   mem_addr, mem_wdata  memory request address / write data
//   mem_start_read/write one-cycle request pulses
//   mem_rdata, mem_busy  memory response
//
// Optional feature macro: ACC_CPU_FREE_RUN_EN (adds the run input).
//
// state      | meaning
// -----------+--------------------------------------------------
// IDLE       | waiting for step/run
// FETCH_REQ  | read request for instruction word at pc
// FETCH_WAIT | dead cycle, then wait for instruction word
// DECODE     | decode, execute 1-word ops, handle skip
// OPER_REQ   | read request for operand word at pc+1
// OPER_WAIT  | dead cycle, then wait for operand; imm ops execute here
// DATA_REQ   | read/write request at RAM[operand]
// DATA_WAIT  | dead cycle, then wait for data; RAM ops execute here
// HALT       | halted until reset
// TRAP       | illegal instruction, stuck until reset
module acc_cpu_core #(
  parameter int          DATA_WIDTH = 16,
  parameter int          ADDR_WIDTH = 16,
  parameter int          OUT_PORTS  = 2,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     step,
`ifdef ACC_CPU_FREE_RUN_EN
  input  logic                     run,
`endif
  output logic                     busy,
  output logic                     halt,
  output logic                     trap,
  input  logic [7:0]               data_in,
  output logic [8*OUT_PORTS-1:0]   data_out,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     mem_start_read,
  output logic                     mem_start_write,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_busy
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_FETCH_REQ  = 4'd1;
  localparam logic [3:0] S_FETCH_WAIT = 4'd2;
  localparam logic [3:0] S_DECODE     = 4'd3;
  localparam logic [3:0] S_OPER_REQ   = 4'd4;
  localparam logic [3:0] S_OPER_WAIT  = 4'd5;
  localparam logic [3:0] S_DATA_REQ   = 4'd6;
  localparam logic [3:0] S_DATA_WAIT  = 4'd7;
  localparam logic [3:0] S_HALT       = 4'd8;
  localparam logic [3:0] S_TRAP       = 4'd9;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_BR    = 4'h8;
  localparam logic [3:0] OP_IF    = 4'h9;
  localparam logic [3:0] OP_OUT   = 4'hA;
  localparam logic [3:0] OP_IN    = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [ADDR_WIDTH-1:0] PC_RST = ADDR_WIDTH'(RESET_PC);

  logic [3:0]              state_q, state_d;
  logic                    dead_q, dead_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   accum_q, accum_d;
  logic                    zero_q, zero_d;
  logic                    carry_q, carry_d;
  logic                    skip_q, skip_d;
  logic                    skipped_q, skipped_d;
  logic [7:0]              ir_q, ir_d;
  logic [8*OUT_PORTS-1:0]  dout_q, dout_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    mem_rd_q, mem_rd_d;
  logic                    mem_wr_q, mem_wr_d;

  logic                    start_req;
  logic [3:0]              opc;
  logic                    src;
  logic [2:0]              sel;
  logic                    two_word;
  logic                    needs_data;
  logic                    cond;
  logic                    if_bad;
  logic                    out_bad;
  logic [ADDR_WIDTH-1:0]   pc_inc1, pc_inc2;
  logic [DATA_WIDTH:0]     sum_ext, diff_ext;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic                    alu_carry;

`ifdef ACC_CPU_FREE_RUN_EN
  assign start_req = step | run;
`else
  assign start_req = step;
`endif

  assign opc        = ir_q[3:0];
  assign src        = ir_q[4];
  assign sel        = ir_q[7:5];
  assign two_word   = (opc >= OP_LOAD) && (opc <= OP_BR);
  // STORE always addresses RAM; src only matters for LOAD and ALU ops.
  assign needs_data = (opc == OP_STORE) ||
                      (src && ((opc == OP_LOAD) || ((opc >= OP_ADD) && (opc <= OP_XOR))));
  assign if_bad     = (sel[2:1] == 2'b11);
  assign out_bad    = (int'(sel) >= OUT_PORTS);
  assign pc_inc1    = pc_q + ADDR_WIDTH'(1);
  assign pc_inc2    = pc_q + ADDR_WIDTH'(2);

  always_comb begin
    case (sel)
      3'd0:    cond = zero_q;
      3'd1:    cond = !zero_q;
      3'd2:    cond = skipped_q;
      3'd3:    cond = !skipped_q;
      3'd4:    cond = carry_q;
      3'd5:    cond = !carry_q;
      default: cond = 1'b0;
    endcase
  end

  // Operand value is always mem_rdata at the cycle the ALU result is taken:
  // immediate ops in OPER_WAIT, RAM ops in DATA_WAIT.
  always_comb begin
    sum_ext   = {1'b0, accum_q} + {1'b0, mem_rdata};
    diff_ext  = {1'b0, accum_q} - {1'b0, mem_rdata};
    alu_res   = mem_rdata;
    alu_carry = carry_q;
    case (opc)
      OP_ADD: begin
        alu_res   = sum_ext[DATA_WIDTH-1:0];
        alu_carry = sum_ext[DATA_WIDTH];
      end
      OP_SUB: begin
        alu_res   = diff_ext[DATA_WIDTH-1:0];
        alu_carry = ~diff_ext[DATA_WIDTH];
      end
      OP_AND:  alu_res = accum_q & mem_rdata;
      OP_OR:   alu_res = accum_q | mem_rdata;
      OP_XOR:  alu_res = accum_q ^ mem_rdata;
      default: alu_res = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dead_d      = 1'b0;
    pc_d        = pc_q;
    accum_d     = accum_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    skip_d      = skip_q;
    skipped_d   = skipped_q;
    ir_d        = ir_q;
    dout_d      = dout_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d    = S_FETCH_REQ;
          mem_addr_d = pc_q;
          mem_rd_d   = 1'b1;
        end
      end

      S_FETCH_REQ: begin
        state_d = S_FETCH_WAIT;
        dead_d  = 1'b1;
      end

      S_FETCH_WAIT: begin
        if (!dead_q && !mem_busy) begin
          ir_d    = mem_rdata[7:0];
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        skipped_d = skip_q;
        state_d   = S_IDLE;
        if (opc == OP_IF) begin
          // IF is evaluated even when it is itself in a skip shadow.
          if (if_bad) begin
            state_d = S_TRAP;
          end else begin
            skip_d = !cond;
            pc_d   = pc_inc1;
          end
        end else if (skip_q) begin
          skip_d = 1'b0;
          pc_d   = two_word ? pc_inc2 : pc_inc1;
        end else begin
          case (opc)
            OP_NOP: pc_d = pc_inc1;
            OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_BR: begin
              state_d    = S_OPER_REQ;
              mem_addr_d = pc_inc1;
              mem_rd_d   = 1'b1;
            end
            OP_OUT: begin
              if (out_bad) begin
                state_d = S_TRAP;
              end else begin
                for (int k = 0; k < OUT_PORTS; k++) begin
                  if (sel == 3'(k)) dout_d[8*k +: 8] = accum_q[7:0];
                end
                pc_d = pc_inc1;
              end
            end
            OP_IN: begin
              accum_d = DATA_WIDTH'(data_in);
              zero_d  = (data_in == 8'd0);
              pc_d    = pc_inc1;
            end
            OP_HALT: state_d = S_HALT;
            default: state_d = S_TRAP;
          endcase
        end
      end

      S_OPER_REQ: begin
        state_d = S_OPER_WAIT;
        dead_d  = 1'b1;
      end

      S_OPER_WAIT: begin
        if (!dead_q && !mem_busy) begin
          if (opc == OP_BR) begin
            pc_d    = pc_inc2 + mem_rdata[ADDR_WIDTH-1:0];
            state_d = S_IDLE;
          end else if (needs_data) begin
            state_d    = S_DATA_REQ;
            mem_addr_d = mem_rdata[ADDR_WIDTH-1:0];
            if (opc == OP_STORE) begin
              mem_wdata_d = accum_q;
              mem_wr_d    = 1'b1;
            end else begin
              mem_rd_d = 1'b1;
            end
          end else begin
            accum_d = alu_res;
            zero_d  = (alu_res == '0);
            carry_d = alu_carry;
            pc_d    = pc_inc2;
            state_d = S_IDLE;
          end
        end
      end

      S_DATA_REQ: begin
        state_d = S_DATA_WAIT;
        dead_d  = 1'b1;
      end

      S_DATA_WAIT: begin
        if (!dead_q && !mem_busy) begin
          if (opc != OP_STORE) begin
            accum_d = alu_res;
            zero_d  = (alu_res == '0);
            carry_d = alu_carry;
          end
          pc_d    = pc_inc2;
          state_d = S_IDLE;
        end
      end

      S_HALT:  state_d = S_HALT;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dead_q      <= 1'b0;
      pc_q        <= PC_RST;
      accum_q     <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      skip_q      <= 1'b0;
      skipped_q   <= 1'b0;
      ir_q        <= '0;
      dout_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      dead_q      <= dead_d;
      pc_q        <= pc_d;
      accum_q     <= accum_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      skip_q      <= skip_d;
      skipped_q   <= skipped_d;
      ir_q        <= ir_d;
      dout_q      <= dout_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  assign busy            = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_TRAP);
  assign halt            = (state_q == S_HALT);
  assign trap            = (state_q == S_TRAP);
  assign data_out        = dout_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_start_read  = mem_rd_q;
  assign mem_start_write = mem_wr_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
module tb_acc_cpu_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step = 1'b0;
  logic [7:0]  data_in = 8'hA5;
  logic        busy, halt, trap;
  logic [15:0] data_out;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_start_read, mem_start_write;
  logic [15:0] mem_rdata;
  logic        mem_busy;
`ifdef ACC_CPU_FREE_RUN_EN
  logic        run = 1'b0;
`endif

  acc_cpu_core dut (
    .clk(clk), .rst_n(rst_n), .step(step),
`ifdef ACC_CPU_FREE_RUN_EN
    .run(run),
`endif
    .busy(busy), .halt(halt), .trap(trap), .data_in(data_in), .data_out(data_out),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_start_read(mem_start_read),
    .mem_start_write(mem_start_write), .mem_rdata(mem_rdata), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- memory model ----------------
  logic [15:0] prog [0:255];
  logic [15:0] mem  [0:255];
  int          lat = 0;
  logic        pulse_err = 1'b0;
  logic [15:0] last_wa = '0, last_wd = '0;

  initial begin
    logic       pend;
    int         cnt;
    logic [7:0] paddr;
    logic       prev_start;
    pend = 0; cnt = 0; paddr = '0; prev_start = 0;
    mem_busy = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        mem_busy = 1'b0; pend = 0; prev_start = 0;
        for (int i = 0; i < 256; i++) mem[i] = prog[i];
      end else begin
        if (pend) begin
          if (cnt == 0) begin
            mem_busy = 1'b0; mem_rdata = mem[paddr]; pend = 0;
          end else cnt--;
        end
        if (mem_start_read || mem_start_write) begin
          if (prev_start) pulse_err = 1'b1;
          paddr = mem_addr[7:0];
          if (mem_start_write) begin
            mem[paddr] = mem_wdata; last_wa = mem_addr; last_wd = mem_wdata;
          end
          pend = 1; cnt = lat; mem_busy = 1'b1;
        end
        prev_start = mem_start_read || mem_start_write;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    string       tag;
    logic [15:0] acc;
    logic        z, c;
    logic [15:0] pc, dout;
    logic        h, t;
    int          min_busy;
    logic        chk_mem, chk_wr;
    logic [15:0] wa, wd;
  } exp_t;

  exp_t exp_q[$];
  logic chk_req = 1'b0;

  task automatic cmp(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_st(string tag, logic [15:0] acc, logic z, logic c, logic [15:0] pc,
                           logic [15:0] dout, logic h = 1'b0, logic t = 1'b0, int min_busy = 0,
                           logic chk_mem = 1'b0, logic chk_wr = 1'b0,
                           logic [15:0] wa = 16'h0, logic [15:0] wd = 16'h0);
    exp_t e;
    e.tag = tag; e.acc = acc; e.z = z; e.c = c; e.pc = pc; e.dout = dout; e.h = h; e.t = t;
    e.min_busy = min_busy; e.chk_mem = chk_mem; e.chk_wr = chk_wr; e.wa = wa; e.wd = wd;
    exp_q.push_back(e);
  endtask

  initial begin
    logic prev_busy;
    int   busy_len;
    exp_t e;
    prev_busy = 1'b0; busy_len = 0;
    forever begin
      @(negedge clk);
      if (busy) busy_len++;
      if ((prev_busy && !busy && rst_n) || chk_req) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL scoreboard_empty: got an output event, expected none");
        end else begin
          e = exp_q.pop_front();
          cmp({e.tag, ".acc"},   32'(dut.accum_q), 32'(e.acc));
          cmp({e.tag, ".zero"},  32'(dut.zero_q),  32'(e.z));
          cmp({e.tag, ".carry"}, 32'(dut.carry_q), 32'(e.c));
          cmp({e.tag, ".pc"},    32'(dut.pc_q),    32'(e.pc));
          cmp({e.tag, ".dout"},  32'(data_out),    32'(e.dout));
          cmp({e.tag, ".halt"},  32'(halt),        32'(e.h));
          cmp({e.tag, ".trap"},  32'(trap),        32'(e.t));
          cmp({e.tag, ".busy"},  32'(busy),        32'd0);
          cmp({e.tag, ".pulse"}, 32'(pulse_err),   32'd0);
          if (e.min_busy > 0) cmp({e.tag, ".busy_long"}, 32'(busy_len >= e.min_busy), 32'd1);
          if (e.chk_mem) begin
            cmp({e.tag, ".mem_addr"},  32'(mem_addr),  32'd0);
            cmp({e.tag, ".mem_wdata"}, 32'(mem_wdata), 32'd0);
            cmp({e.tag, ".mem_start"}, 32'({mem_start_read, mem_start_write}), 32'd0);
          end
          if (e.chk_wr) begin
            cmp({e.tag, ".wr_addr"}, 32'(last_wa), 32'(e.wa));
            cmp({e.tag, ".wr_data"}, 32'(last_wd), 32'(e.wd));
          end
        end
        busy_len = 0;
      end
      if (!rst_n) busy_len = 0;
      prev_busy = busy;
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_test(int latency);
    rst_n = 1'b0;
    lat = latency;
    for (int i = 0; i < 256; i++) prog[i] = 16'h0;
  endtask

  task automatic release_rst();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_step();
    int n;
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL step_timeout: busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic request_check();
    @(posedge clk); chk_req = 1'b1;
    @(posedge clk); chk_req = 1'b0;
  endtask

  task automatic load(input logic [15:0] words[], input int base = 0);
    foreach (words[i]) prog[base + i] = words[i];
  endtask

  initial begin
    int n;
    // T1: LOAD RAM[5], OUT port0
    start_test(2);
    load('{16'h0011, 16'h0005, 16'h000A});
    prog[5] = 16'h0005;
    release_rst();
    expect_st("rst", 16'h0, 0, 0, 16'h0, 16'h0, .chk_mem(1'b1));
    request_check();
    expect_st("t1_load", 16'h0005, 0, 0, 16'd2, 16'h0000); do_step();
    expect_st("t1_out0", 16'h0005, 0, 0, 16'd3, 16'h0005); do_step();

    // T2: carry from ADD, IF carry, OUT port1
    start_test(2);
    load('{16'h0001, 16'hFFFF, 16'h0003, 16'h0001, 16'h0089, 16'h002A});
    release_rst();
    expect_st("t2_load", 16'hFFFF, 0, 0, 16'd2, 16'h0); do_step();
    expect_st("t2_add",  16'h0000, 1, 1, 16'd4, 16'h0); do_step();
    expect_st("t2_if",   16'h0000, 1, 1, 16'd5, 16'h0); do_step();
    expect_st("t2_out1", 16'h0000, 1, 1, 16'd6, 16'h0); do_step();

    // T3: skip chain, SUB borrow/no-borrow, XOR, IN, backward BR
    start_test(1);
    load('{16'h0001, 16'h0005, 16'h0009, 16'h000A, 16'h0049, 16'h002A,
           16'h0004, 16'h0006, 16'h0004, 16'hFFFF, 16'h0007, 16'h00F0,
           16'h000B, 16'h0008, 16'hFFFD});
    release_rst();
    expect_st("t3_load",  16'h0005, 0, 0, 16'd2,  16'h0000); do_step();
    expect_st("t3_ifz",   16'h0005, 0, 0, 16'd3,  16'h0000); do_step();
    expect_st("t3_skip",  16'h0005, 0, 0, 16'd4,  16'h0000); do_step();
    expect_st("t3_ifsk",  16'h0005, 0, 0, 16'd5,  16'h0000); do_step();
    expect_st("t3_out1",  16'h0005, 0, 0, 16'd6,  16'h0500); do_step();
    expect_st("t3_sub_b", 16'hFFFF, 0, 0, 16'd8,  16'h0500); do_step();
    expect_st("t3_sub_n", 16'h0000, 1, 1, 16'd10, 16'h0500); do_step();
    expect_st("t3_xor",   16'h00F0, 0, 1, 16'd12, 16'h0500); do_step();
    expect_st("t3_in",    16'h00A5, 0, 1, 16'd13, 16'h0500); do_step();
    expect_st("t3_br",    16'h00A5, 0, 1, 16'd12, 16'h0500); do_step();

    // T4: STORE / LOAD RAM with a long mem_busy
    start_test(20);
    load('{16'h0001, 16'h1234, 16'h0002, 16'h0040, 16'h0001, 16'h0000, 16'h0011, 16'h0040});
    release_rst();
    expect_st("t4_load", 16'h1234, 0, 0, 16'd2, 16'h0, 0, 0, 40); do_step();
    expect_st("t4_store", 16'h1234, 0, 0, 16'd4, 16'h0, 0, 0, 60, 0, 1, 16'h0040, 16'h1234); do_step();
    expect_st("t4_clr",  16'h0000, 1, 0, 16'd6, 16'h0, 0, 0, 40, 0, 1, 16'h0040, 16'h1234); do_step();
    expect_st("t4_ldram", 16'h1234, 0, 0, 16'd8, 16'h0, 0, 0, 60, 0, 1, 16'h0040, 16'h1234); do_step();

    // T5: trap / halt / skipped halt / OUT port out of range
    start_test(0);
    prog[0] = 16'h000C;
    release_rst();
    expect_st("t5_trap", 16'h0, 0, 0, 16'd0, 16'h0, 0, 1); do_step();
    do_step();
    expect_st("t5_trap_sticky", 16'h0, 0, 0, 16'd0, 16'h0, 0, 1);
    request_check();

    start_test(0);
    load('{16'h0009, 16'h000F, 16'h000F});
    release_rst();
    expect_st("t5_ifz",     16'h0, 0, 0, 16'd1, 16'h0); do_step();
    expect_st("t5_skiphlt", 16'h0, 0, 0, 16'd2, 16'h0); do_step();
    expect_st("t5_halt",    16'h0, 0, 0, 16'd2, 16'h0, 1, 0); do_step();
    do_step();
    expect_st("t5_halt_sticky", 16'h0, 0, 0, 16'd2, 16'h0, 1, 0);
    request_check();

    start_test(0);
    prog[0] = 16'h00EA;
    release_rst();
    expect_st("t5_outbad", 16'h0, 0, 0, 16'd0, 16'h0, 0, 1); do_step();

    // T6: reset while waiting for an operand
    start_test(30);
    load('{16'h0001, 16'h0077});
    release_rst();
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    n = 0;
    while (dut.state_q != 4'd5 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      total++; bad++;
      $display("FAIL t6_reach_oper_wait: state 0x%0h, expected 0x5", dut.state_q);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    expect_st("t6_rst", 16'h0, 0, 0, 16'd0, 16'h0, .chk_mem(1'b1));
    request_check();
    lat = 0;
    release_rst();
    expect_st("t6_refetch", 16'h0077, 0, 0, 16'd2, 16'h0); do_step();

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/acc_cpu_core.md
Name: acc_cpu_core

Overview:
- Parametrised next-generation accumulator CPU core; successor to the 16-bit single-step accumulator CPU.
- Generalised in data width, address width and output-port count.
- Adds STORE, SUB and logic ops, IN, HALT, and a carry flag with carry conditions.
- Talks to the external SPI RAM controller through a generic start/busy memory handshake; sits between the top-level pin wrapper and that controller.

Parameters:
- DATA_WIDTH, 16, accumulator/memory word width (>=8).
- ADDR_WIDTH, 16, word-address width (<=DATA_WIDTH).
- OUT_PORTS, 2, number of 8-bit output ports (1..8).
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- step  in  1  in IDLE, starts execution of one instruction
- busy  out  1  high in every state except IDLE/HALT/TRAP
- halt  out  1  high in HALT
- trap  out  1  high in TRAP
- data_in  in  8  IN instruction source
- data_out  out  8*OUT_PORTS  packed output ports; port k = bits [8k+7:8k]
- mem_addr  out  ADDR_WIDTH  memory word address
- mem_wdata  out  DATA_WIDTH  write data
- mem_start_read  out  1  one-cycle read request
- mem_start_write  out  1  one-cycle write request
- mem_rdata  in  DATA_WIDTH  read data, valid when mem_busy low after a request
- mem_busy  in  1  memory operation in progress

Behaviour:
- Reset (async): state=IDLE, pc=RESET_PC, accum=0, zero=0, carry=0, skip=0, skipped=0, data_out=0, mem_start_*=0, mem_addr=0, mem_wdata=0.
- Memory handshake:
  - Start pulse lasts exactly one cycle with addr/wdata valid.
  - The following cycle is a dead cycle; mem_busy is not sampled.
  - From then on, wait until mem_busy=0; mem_rdata is captured in that cycle.
- Instruction word fields:
  - [3:0] opcode.
  - [4] src: 0=immediate, 1=RAM[operand].
  - [7:5] sel: condition or port index.
  - Two-word instructions take their operand from word pc+1.
- Opcodes:
  - 0 NOP (1 word).
  - 1 LOAD, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR (2 words): accum op= value.
  - 2 STORE (2 words): RAM[operand] <= accum; src ignored.
  - 8 BR (2 words): pc <= pc+2+operand (mod 2^ADDR_WIDTH).
  - 9 IF (1 word): sel 0=zero, 1=!zero, 2=skipped, 3=!skipped, 4=carry, 5=!carry; 6-7 trap.
  - A OUT (1 word): data_out[sel] <= accum[7:0]; sel>=OUT_PORTS traps.
  - B IN (1 word): accum <= zero-extended data_in.
  - F HALT.
  - C-E: trap.
- Flags:
  - LOAD/IN/logic ops: update zero only.
  - ADD/SUB: update zero and carry (ADD carry-out; SUB carry=1 when no borrow).
  - Result width is DATA_WIDTH, wrapping.
- States:
  - IDLE -(step)-> FETCH_REQ -> FETCH_WAIT -> DECODE.
  - DECODE goes to:
    - OPER_REQ for 2-word non-skipped instructions, or
    - IDLE when complete, or
    - HALT / TRAP.
  - OPER_REQ -> OPER_WAIT.
  - OPER_WAIT goes to DATA_REQ for src=1 loads/ALU ops and STORE; otherwise executes and returns to IDLE.
  - DATA_REQ -> DATA_WAIT -> execute -> IDLE.
- Skip rules:
  - IF sets skip = NOT(condition); IF evaluates even while skip is set.
  - Skipped non-IF instruction:
    - no operand or data access, no side effects;
    - pc advances by its length;
    - a skipped HALT does not halt.
  - At every DECODE: skipped <= skip. Any non-IF instruction clears skip on completion.
- PC: advances by instruction length on completion; wraps mod 2^ADDR_WIDTH.
- HALT/TRAP are sticky until reset; step is ignored there.
- Reset mid-operation: immediate return to reset values; outstanding memory ops are abandoned (controller reset by same rst_n).
- step held high: a new instruction starts only on return to IDLE; each IDLE cycle with step=1 starts one instruction.

Optional Feature:
- Macro ACC_CPU_FREE_RUN_EN.
- Defined: adds input port run (1 bit). While run=1, IDLE advances to FETCH_REQ without step (continuous execution; step is still honoured when run=0).
- Undefined: no run port; only step starts instructions.

Test Plan:
- Reset with RAM {0x0011,0x0005,0x000A}, step x2: accum=0x0005, zero=0; second instruction OUT port0 -> data_out[7:0]=0x05, pc=3, busy low after each.
- LOAD imm 0xFFFF, ADD imm 0x0001: accum=0x0000, zero=1, carry=1; then IF carry (0x0089) followed by OUT port1 (0x002A) -> data_out[15:8]=0x00 written, pc advances 2+2+1+1.
- LOAD imm 5, IF zero, OUT port0, IF skipped (0x0049), OUT port1: OUT0 skipped (data_out[7:0] stays 0); OUT1 writes 0x05 to data_out[15:8].
- STORE 0x0040 with accum=0x1234, then LOAD RAM 0x0040 (0x0011,0x0040): mem_start_write pulse with addr 0x0040 / wdata 0x1234; accum reads back 0x1234; busy holds through a mem_busy stretched to 20 cycles.
- Opcode 0x000C -> trap=1 after DECODE, further steps ignored; opcode 0x000F -> halt=1; OUT sel=7 with OUT_PORTS=2 -> trap=1.
- Assert rst_n=0 during OPER_WAIT: all outputs return to reset values asynchronously; next step fetches from RESET_PC.
